plru_table: RTL and testbench

Per-set storage and sequencing for the 8-way tree pseudo-LRU replacement state of a set-associative cache. It holds one 7-bit tree-PLRU word per set and applies way-hit updates ("touches") from the cache pipeline. It answers victim queries with a registered way number. After reset or flush it clears all sets with a one-set-per-cycle init sweep. It sits beside the cache tag/data arrays and is the consumer of the tree-PLRU encoding used by the cache's replacement logic.

---
 rtl/plru_table_if.sv | 22 ++
 rtl/plru_table.sv | 76 +++++++
 tb/tb_plru_table.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/plru_table_if.sv
// plru_table_if: touch, victim-query and flush/sweep signals between the cache pipeline and plru_table.
interface plru_table_if #(parameter int NUM_SETS = 64);
  localparam int IW = $clog2(NUM_SETS);
  logic          flush;
  logic          init_busy;
  logic          touch_valid;
  logic [IW-1:0] touch_index;
  logic [2:0]    touch_way;
  logic          q_valid;
  logic [IW-1:0] q_index;
  logic          q_ready;
  logic          victim_valid;
  logic [2:0]    victim_way;
  modport master (
    output flush, touch_valid, touch_index, touch_way, q_valid, q_index,
    input  init_busy, q_ready, victim_valid, victim_way
  );
  modport slave (
    input  flush, touch_valid, touch_index, touch_way, q_valid, q_index,
    output init_busy, q_ready, victim_valid, victim_way
  );
endinterface

// File: rtl/plru_table.sv
// plru_table: per-set 8-way tree-PLRU state with touch updates, bypassed victim queries and an init sweep.
module plru_table #(
  parameter int NUM_SETS      = 64,
  parameter int ASSOCIATIVITY = 8
) (
  input logic        clk,
  input logic        reset,
  plru_table_if.slave bus
);
  localparam int IW = $clog2(NUM_SETS);
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  if (ASSOCIATIVITY != 8) begin : g_assoc_check
    $error("plru_table supports only ASSOCIATIVITY = 8");
  end
  function automatic logic [2:0] victim_of(input logic [6:0] s);
    logic       v1;
    logic [2:0] leaf;
    v1   = s[0] ? s[2] : s[1];
    leaf = 3'd3 + {1'b0, s[0], v1};
    return {s[0], v1, s[leaf]};
  endfunction
  function automatic logic [6:0] touched(input logic [6:0] s, input logic [2:0] h);
    logic [6:0] t;
    logic [2:0] leaf;
    t    = s;
    leaf = 3'd3 + {1'b0, h[2:1]};
    t[0] = ~h[2];
    if (h[2]) t[2] = ~h[1];
    else      t[1] = ~h[1];
    t[leaf] = ~h[0];
    return t;
  endfunction
  logic [0:0]    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          victim_valid_q, victim_valid_d;
  logic [2:0]    victim_way_q, victim_way_d;
  logic [6:0]    mem_q [NUM_SETS];
  logic          run, accept, wr_en;
  logic [IW-1:0] wr_idx;
  logic [6:0]    wr_data, touch_s, q_s;
  always_comb begin
    run     = state_q == RUN;
    touch_s = touched(mem_q[bus.touch_index], bus.touch_way);
    // same-set touch in this cycle is folded into the query so the victim never hits the touched way
    q_s     = (bus.touch_valid && bus.touch_index == bus.q_index) ? touch_s : mem_q[bus.q_index];
    accept  = run && bus.q_valid;
    wr_en   = !run || bus.touch_valid;
    wr_idx  = run ? bus.touch_index : cnt_q;
    wr_data = run ? touch_s : 7'd0;
    cnt_d   = bus.flush ? '0 : run ? cnt_q : cnt_q + 1'b1;
    state_d = bus.flush ? INIT : (!run && cnt_q == IW'(NUM_SETS - 1)) ? RUN : state_q;
    victim_valid_d = accept;
    victim_way_d   = accept ? victim_of(q_s) : victim_way_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= INIT;
      cnt_q          <= '0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= 3'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end
  assign bus.init_busy    = !run;
  assign bus.q_ready      = run;
  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_way   = victim_way_q;
endmodule

// File: tb/tb_plru_table.sv
// tb_plru_table: directed and randomized checks of plru_table against a recency-timestamp PLRU model.
module tb_plru_table;
  localparam int NS = 64;
  localparam int IW = $clog2(NS);
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int ts [NS][8];
  int now_t;
  int busy_cnt;
  logic exp_vv;
  logic [2:0] exp_way;
  always #5 clk = ~clk;
  plru_table_if #(.NUM_SETS(NS)) bus ();
  plru_table #(.NUM_SETS(NS), .ASSOCIATIVITY(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  // tree PLRU: each node steers away from the half that holds the most recent touch below it
  function automatic logic [2:0] model_victim(input int idx);
    int lo, size, half, ml, mr;
    lo = 0;
    size = 8;
    while (size > 1) begin
      half = size / 2;
      ml = 0;
      mr = 0;
      for (int k = 0; k < half; k++) begin
        if (ts[idx][lo + k] > ml) ml = ts[idx][lo + k];
        if (ts[idx][lo + half + k] > mr) mr = ts[idx][lo + half + k];
      end
      if (ml > mr) lo += half;
      size = half;
    end
    return 3'(lo);
  endfunction
  task automatic clear_model();
    foreach (ts[i, j]) ts[i][j] = 0;
    now_t = 0;
  endtask
  task automatic cycle(input logic tv, input int ti, input int tw, input logic qv, input int qi, input logic fl);
    bus.touch_valid = tv;
    bus.touch_index = IW'(ti);
    bus.touch_way   = 3'(tw);
    bus.q_valid     = qv;
    bus.q_index     = IW'(qi);
    bus.flush       = fl;
    if (busy_cnt == 0 && tv) begin
      now_t++;
      ts[ti][tw] = now_t;
    end
    exp_vv = busy_cnt == 0 && qv;
    if (exp_vv) exp_way = model_victim(qi);
    if (fl) begin
      clear_model();
      busy_cnt = NS;
    end else if (busy_cnt > 0) busy_cnt--;
    @(posedge clk);
    #1;
    bus.touch_valid = 1'b0;
    bus.q_valid     = 1'b0;
    bus.flush       = 1'b0;
  endtask
  task automatic test_reset();
    int n;
    reset = 1'b1;
    bus.flush = 1'b0; bus.touch_valid = 1'b0; bus.touch_index = '0; bus.touch_way = '0;
    bus.q_valid = 1'b0; bus.q_index = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.init_busy !== 1'b1 || bus.q_ready !== 1'b0 || bus.victim_valid !== 1'b0 || bus.victim_way !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b ready=%b vv=%b way=%0d, required 1 0 0 0",
               bus.init_busy, bus.q_ready, bus.victim_valid, bus.victim_way);
    end
    reset = 1'b0;
    clear_model();
    busy_cnt = NS;
    n = 0;
    while (bus.init_busy === 1'b1 && n < 200) begin
      n++;
      cycle(0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (n != NS || bus.q_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_sweep: busy_cycles=%0d ready=%b, required %0d and 1", n, bus.q_ready, NS);
    end
    cycle(0, 0, 0, 1, 5, 0);
    checks++;
    if (bus.victim_valid !== 1'b1 || bus.victim_way !== 3'd0) begin
      errors++;
      $display("FAIL reset_query5: vv=%b way=%0d, required 1 and 0", bus.victim_valid, bus.victim_way);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.victim_valid !== 1'b0) begin
      errors++;
      $display("FAIL victim_pulse: vv=%b, required 0", bus.victim_valid);
    end
  endtask
  task automatic test_sequence();
    int ways [3] = '{0, 4, 2};
    int vic  [3] = '{4, 2, 6};
    for (int i = 0; i < 3; i++) begin
      cycle(1, 3, ways[i], 0, 0, 0);
      cycle(0, 0, 0, 1, 3, 0);
      checks++;
      if (bus.victim_valid !== 1'b1 || bus.victim_way !== 3'(vic[i])) begin
        errors++;
        $display("FAIL seq_set3_%0d: vv=%b way=%0d, required 1 and %0d", i, bus.victim_valid, bus.victim_way, vic[i]);
      end
    end
  endtask
  task automatic test_bypass();
    cycle(1, 7, 0, 1, 7, 0);
    checks++;
    if (bus.victim_valid !== 1'b1 || bus.victim_way !== 3'd4) begin
      errors++;
      $display("FAIL bypass_same: vv=%b way=%0d, required 1 and 4", bus.victim_valid, bus.victim_way);
    end
    cycle(1, 7, 0, 1, 8, 0);
    checks++;
    if (bus.victim_valid !== 1'b1 || bus.victim_way !== 3'd0) begin
      errors++;
      $display("FAIL bypass_other: vv=%b way=%0d, required 1 and 0", bus.victim_valid, bus.victim_way);
    end
  endtask
  task automatic test_back_to_back();
    for (int w = 0; w < 8; w++) cycle(1, 1, w, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    checks++;
    if (bus.victim_valid !== 1'b1 || bus.victim_way !== 3'd0) begin
      errors++;
      $display("FAIL all_ways: vv=%b way=%0d, required 1 and 0", bus.victim_valid, bus.victim_way);
    end
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    checks++;
    if (bus.victim_valid !== 1'b1 || bus.victim_way !== 3'd4) begin
      errors++;
      $display("FAIL retouch0: vv=%b way=%0d, required 1 and 4", bus.victim_valid, bus.victim_way);
    end
  endtask
  task automatic test_flush();
    int n;
    logic bad;
    cycle(1, 9, 0, 0, 0, 0);
    checks++;
    if (bus.q_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle_ready: ready=%b, required 1", bus.q_ready);
    end
    cycle(0, 0, 0, 1, 9, 1);
    checks++;
    if (bus.victim_valid !== 1'b1 || bus.victim_way !== 3'd4 || bus.init_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_query: vv=%b way=%0d busy=%b, required 1 4 1", bus.victim_valid, bus.victim_way, bus.init_busy);
    end
    n = 0;
    bad = 1'b0;
    while (bus.init_busy === 1'b1 && n < 200) begin
      if (bus.q_ready !== 1'b0) bad = 1'b1;
      cycle(n == 10, 9, 4, 1, 9, 0);
      if (bus.victim_valid !== 1'b0) bad = 1'b1;
      n++;
    end
    checks++;
    if (n != NS || bad) begin
      errors++;
      $display("FAIL flush_sweep: busy_cycles=%0d ready_or_victim_during_init=%b, required %0d and 0", n, bad, NS);
    end
    cycle(0, 0, 0, 1, 9, 0);
    checks++;
    if (bus.victim_valid !== 1'b1 || bus.victim_way !== 3'd0) begin
      errors++;
      $display("FAIL flush_cleared: vv=%b way=%0d, required 1 and 0", bus.victim_valid, bus.victim_way);
    end
  endtask
  task automatic test_midsweep_restart();
    int n;
    cycle(1, 2, 3, 0, 0, 1);
    for (int i = 0; i < 20; i++) cycle(1, 2, i % 8, 1, 2, 0);
    cycle(1, 2, 5, 1, 2, 1);
    n = 1;
    while (bus.init_busy === 1'b1 && n < 200) begin
      cycle(1, 2, 1, 1, 2, 0);
      n++;
    end
    checks++;
    if (n != NS + 1) begin
      errors++;
      $display("FAIL midsweep_restart: busy_cycles=%0d, required %0d", n - 1, NS);
    end
    cycle(0, 0, 0, 1, 2, 0);
    checks++;
    if (bus.victim_valid !== 1'b1 || bus.victim_way !== 3'd0) begin
      errors++;
      $display("FAIL init_ignored: vv=%b way=%0d, required 1 and 0", bus.victim_valid, bus.victim_way);
    end
  endtask
  task automatic test_reset_squash();
    int n;
    bus.q_valid = 1'b1;
    bus.q_index = IW'(4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.q_valid = 1'b0;
    clear_model();
    busy_cnt = NS;
    checks++;
    if (bus.victim_valid !== 1'b0 || bus.init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_squash: vv=%b busy=%b, required 0 and 1", bus.victim_valid, bus.init_busy);
    end
    n = 0;
    while (bus.init_busy === 1'b1 && n < 200) begin
      cycle(0, 0, 0, 0, 0, 0);
      n++;
    end
    checks++;
    if (n != NS) begin
      errors++;
      $display("FAIL reset_squash_sweep: busy_cycles=%0d, required %0d", n, NS);
    end
  endtask
  task automatic test_random();
    int bad_state = 0;
    int bad_vic = 0;
    for (int i = 0; i < 4000; i++) begin
      if (bus.q_ready !== (busy_cnt == 0) || bus.init_busy !== (busy_cnt != 0)) bad_state++;
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 399) == 0);
      if (bus.victim_valid !== exp_vv || (exp_vv && bus.victim_way !== exp_way)) begin
        bad_vic++;
        if (bad_vic <= 5)
          $display("FAIL random_victim cycle %0d: vv=%b way=%0d, required %b and %0d",
                   i, bus.victim_valid, bus.victim_way, exp_vv, exp_way);
      end
    end
    checks++;
    if (bad_state != 0) begin
      errors++;
      $display("FAIL random_state: %0d cycles with wrong ready/busy, required 0", bad_state);
    end
    checks++;
    if (bad_vic != 0) begin
      errors++;
      $display("FAIL random_victims: %0d wrong victim cycles, required 0", bad_vic);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_sequence();
    test_bypass();
    test_back_to_back();
    test_flush();
    test_midsweep_restart();
    test_reset_squash();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
